// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier controller.
package mult_pkg;

    localparam int DEF_IN_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/part_prod_row.sv
// One partial-product row of the shift-add multiplier, purely combinational.
module part_prod_row
    import mult_pkg::*;
#(
    parameter int IN_WIDTH = DEF_IN_WIDTH,
    localparam int OUT_WIDTH = 2 * IN_WIDTH,
    localparam int CNT_W = $clog2(IN_WIDTH)
) (
    input  logic [IN_WIDTH-1:0]  op1,
    input  logic                 mul_bit,
    input  logic                 is_signed,
    input  logic                 last_row,
    input  logic [CNT_W-1:0]     row_idx,
    output logic [OUT_WIDTH-1:0] row
);

    logic [OUT_WIDTH-1:0] ext;
    logic [OUT_WIDTH-1:0] shifted;

    always_comb begin
        ext     = is_signed ? {{IN_WIDTH{op1[IN_WIDTH-1]}}, op1}
                            : {{IN_WIDTH{1'b0}}, op1};
        shifted = ext << row_idx;
        row     = '0;
        // The multiplier's sign bit carries weight -2^(N-1) in two's complement.
        if (mul_bit)
            row = (is_signed && last_row) ? -shifted : shifted;
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential multiplier: accepts an operand pair, accumulates one row per cycle,
// then holds the product until the consumer takes it.
//
//   state | meaning
//   IDLE  | waiting for an operand pair, in_ready high
//   BUSY  | accumulating partial-product row cnt
//   DONE  | product valid, waiting for out_ready
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int IN_WIDTH = DEF_IN_WIDTH,
    localparam int OUT_WIDTH = 2 * IN_WIDTH,
    localparam int CNT_W = $clog2(IN_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  op1,
    input  logic [IN_WIDTH-1:0]  op2,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] product,
    output logic                 busy
);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [OUT_WIDTH-1:0] acc;
    logic [IN_WIDTH-1:0]  op1_q;
    logic [IN_WIDTH-1:0]  op2_q;
    logic                 signed_q;
    logic                 last_row;
    logic [OUT_WIDTH-1:0] row;

    assign last_row = (cnt == CNT_W'(IN_WIDTH - 1));

    part_prod_row #(.IN_WIDTH(IN_WIDTH)) u_row (
        .op1       (op1_q),
        .mul_bit   (op2_q[cnt]),
        .is_signed (signed_q),
        .last_row  (last_row),
        .row_idx   (cnt),
        .row       (row)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            signed_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op1_q    <= op1;
                        op2_q    <= op2;
                        signed_q <= is_signed;
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    acc <= acc + row;
                    cnt <= cnt + CNT_W'(1);
                    if (last_row)
                        state <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake flags decode straight from state; the accumulator is the product.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY);
    assign product   = acc;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: directed corners plus random traffic
// against an arithmetic reference product.
module tb_mult_seq_ctrl;

    localparam int W  = 8;
    localparam int OW = 2 * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  op1 = '0;
    logic [W-1:0]  op2 = '0;
    logic          is_signed = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [OW-1:0] product;
    logic          busy;

    mult_seq_ctrl #(.IN_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    int            cyc = 0;
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] exp_next = '0;
    bit            acc_flag = 0;
    int            accept_cyc = 0;
    int            last_accept = -1;
    bit            b2b_mode = 0;
    bit            prev_ov = 0;
    bit            prev_or = 0;
    logic [OW-1:0] prev_prod = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic logic [OW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input bit s);
        longint x, y, p;
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'(a);
            y = longint'(b);
        end
        p = x * y;
        return p[OW-1:0];
    endfunction

    // Acceptance detector: a pair seen with in_valid && in_ready is taken at the next edge.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            exp_q.push_back(exp_next);
            if (last_accept >= 0) begin
                chk("accept_interval_min", ((cyc + 1 - last_accept) >= W + 1), 1);
                if (b2b_mode)
                    chk("accept_interval_b2b", cyc + 1 - last_accept, W + 2);
            end
            accept_cyc  = cyc + 1;
            last_accept = cyc + 1;
            acc_flag    = 1;
        end
    end

    // Monitor: latency, hold-under-backpressure, return to idle and product value.
    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 0;
            prev_or = 0;
        end else begin
            if (out_valid && !prev_ov)
                chk("out_valid_latency", cyc - accept_cyc, W);
            if (prev_ov && !prev_or) begin
                chk("hold_out_valid", out_valid, 1);
                chk("hold_product", product, prev_prod);
                chk("hold_in_ready", in_ready, 0);
            end
            if (prev_ov && prev_or) begin
                chk("idle_after_deliver_in_ready", in_ready, 1);
                chk("idle_after_deliver_out_valid", out_valid, 0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    chk("product", product, exp_q.pop_front());
                end
            end
            prev_ov   = out_valid;
            prev_or   = out_ready;
            prev_prod = product;
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                        input logic [OW-1:0] e, input bit hold_valid, output int waited);
        bit got;
        op1       = a;
        op2       = b;
        is_signed = s;
        exp_next  = e;
        in_valid  = 1'b1;
        got       = 0;
        waited    = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(posedge clk);
            if (acc_flag) begin
                got      = 1;
                acc_flag = 0;
            end else begin
                waited++;
            end
        end
        if (!got) chk("accept_timeout", 0, 1);
        #1;
        if (!hold_valid) in_valid = 1'b0;
        op1       = W'($urandom);
        op2       = W'($urandom);
        is_signed = 1'($urandom);
    endtask

    task automatic wait_drained();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 500) begin
            @(posedge clk);
            k++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_product"}, product, 0);
    endtask

    initial begin
        int wt;
        logic [W-1:0] a, b;
        bit s;

        #2;
        reset_checks("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // First edge after reset release must accept.
        send(8'd3, 8'd5, 1'b0, 16'h000F, 1'b0, wt);
        chk("accept_first_edge_after_reset", wt, 0);
        wait_drained();

        send(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0, wt);
        wait_drained();
        send(8'hFF, 8'hFF, 1'b1, 16'h0001, 1'b0, wt);
        wait_drained();
        send(8'h80, 8'h80, 1'b1, 16'h4000, 1'b0, wt);
        wait_drained();
        send(8'h80, 8'h7F, 1'b1, 16'hC080, 1'b0, wt);
        wait_drained();

        // Backpressure: hold out_ready low for five cycles in DONE.
        out_ready = 1'b0;
        send(8'd200, 8'd117, 1'b0, 16'h5B68, 1'b0, wt);
        for (int k = 0; k < 100 && !out_valid; k++) begin
            @(posedge clk);
            #1;
        end
        chk("bp_reached_done", out_valid, 1);
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drained();

        // Reset in the middle of an operation: cnt=4 after four BUSY edges.
        send(8'h5A, 8'hC3, 1'b1, ref_mul(8'h5A, 8'hC3, 1'b1), 1'b0, wt);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        reset_checks("midop_reset");
        exp_q.delete();
        acc_flag    = 0;
        last_accept = -1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'd7, 8'd6, 1'b0, 16'h002A, 1'b0, wt);
        wait_drained();

        // Back-to-back random pairs with in_valid held high.
        b2b_mode    = 1;
        last_accept = -1;
        for (int n = 0; n < 1000; n++) begin
            a = W'($urandom);
            b = W'($urandom);
            s = 1'($urandom);
            if (n < 8) begin
                a = (n % 2 == 0) ? 8'h80 : 8'h7F;
                b = (n < 4) ? 8'h80 : 8'hFF;
            end
            send(a, b, s, ref_mul(a, b, s), 1'b1, wt);
        end
        in_valid = 1'b0;
        wait_drained();
        b2b_mode = 0;

        // Random traffic with random consumer stalls.
        for (int n = 0; n < 100; n++) begin
            a = W'($urandom);
            b = W'($urandom);
            s = 1'($urandom);
            fork
                begin
                    for (int k = 0; k < 14; k++) begin
                        out_ready = 1'($urandom_range(0, 2) != 0);
                        @(posedge clk);
                        #1;
                    end
                    out_ready = 1'b1;
                end
                send(a, b, s, ref_mul(a, b, s), 1'b0, wt);
            join
            wait_drained();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
